// File: rtl/dedup_serializer.sv
// Serializes one captured frame of unique/duplicate slot arrays into a stream:
// non-empty unique slots first, then non-empty duplicate slots, one slot per cycle.
module dedup_serializer #(
  parameter int N     = 8,
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N-1:0][WIDTH-1:0]   unique_arr,
  input  logic [N-1:0][WIDTH-1:0]   duplicates_arr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_dup,
  output logic                      out_last,
  output logic                      frame_done,
  output logic [$clog2(N+1)-1:0]    unique_cnt,
  output logic [$clog2(N+1)-1:0]    dup_cnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N+1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N-1);

  typedef enum logic [1:0] {IDLE, SCAN_U, SCAN_D, DONE} state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid-side signals never depend combinationally on ready.
  state_t                   state;
  logic [IW-1:0]            idx;
  logic [N-1:0][WIDTH-1:0]  u_q;
  logic [N-1:0][WIDTH-1:0]  d_q;

  logic [WIDTH-1:0] slot;
  logic             slot_nz;
  logic             rest_u;
  logic             rest_d;
  logic             any_d;
  logic             advance;

  // Everything below is decoded from registered state and captured data.
  always_comb begin
    slot   = '0;
    rest_u = 1'b0;
    rest_d = 1'b0;
    any_d  = 1'b0;
    if (state == SCAN_U)      slot = u_q[idx];
    else if (state == SCAN_D) slot = d_q[idx];
    for (int j = 0; j < N; j++) begin
      if (d_q[j] != '0) begin
        any_d = 1'b1;
        if (j > int'(idx)) rest_d = 1'b1;
      end
      if (u_q[j] != '0 && j > int'(idx)) rest_u = 1'b1;
    end
  end

  assign slot_nz    = (slot != '0);
  assign advance    = !slot_nz || out_ready;
  assign out_valid  = slot_nz;
  assign out_data   = slot;
  assign out_dup    = slot_nz && (state == SCAN_D);
  assign out_last   = slot_nz && ((state == SCAN_U) ? !(rest_u || any_d) : !rest_d);
  assign in_ready   = (state == IDLE);
  assign frame_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      u_q        <= '0;
      d_q        <= '0;
      unique_cnt <= '0;
      dup_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            u_q        <= unique_arr;
            d_q        <= duplicates_arr;
            unique_cnt <= '0;
            dup_cnt    <= '0;
            idx        <= '0;
            state      <= SCAN_U;
          end
        end
        SCAN_U: begin
          if (advance) begin
            if (slot_nz) unique_cnt <= unique_cnt + CW'(1);
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= SCAN_D;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        SCAN_D: begin
          if (advance) begin
            if (slot_nz) dup_cnt <= dup_cnt + CW'(1);
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= DONE;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dedup_serializer.sv
// Directed bench for dedup_serializer: stream order, counts, timing,
// backpressure, back-to-back frames and mid-stream reset.
module tb_dedup_serializer;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int CW = $clog2(N+1);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [N-1:0][W-1:0]   unique_arr;
  logic [N-1:0][W-1:0]   duplicates_arr;
  logic                  out_valid;
  logic                  out_ready;
  logic [W-1:0]          out_data;
  logic                  out_dup;
  logic                  out_last;
  logic                  frame_done;
  logic [CW-1:0]         unique_cnt;
  logic [CW-1:0]         dup_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_dup_q[$];

  // Slot 0 is the rightmost byte of each literal.
  localparam logic [N-1:0][W-1:0] MIX_U  = {8'd2, 8'd1, 8'd5, 8'd9, 8'd7, 8'd3, 8'd0, 8'd0};
  localparam logic [N-1:0][W-1:0] MIX_D  = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5, 8'd3};
  localparam logic [N-1:0][W-1:0] B_U    = {8'd0, 8'd0, 8'd0, 8'd0, 8'h22, 8'd0, 8'd0, 8'h11};
  localparam logic [N-1:0][W-1:0] B_D    = {8'd0, 8'd0, 8'h33, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  localparam logic [N-1:0][W-1:0] DO_D   = {8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  localparam logic [N-1:0][W-1:0] ZERO   = '0;
  localparam logic [N-1:0][W-1:0] JUNK   = {N{8'hEE}};

  dedup_serializer #(.N(N), .WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .unique_arr     (unique_arr),
    .duplicates_arr (duplicates_arr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_dup        (out_dup),
    .out_last       (out_last),
    .frame_done     (frame_done),
    .unique_cnt     (unique_cnt),
    .dup_cnt        (dup_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mixed();
    exp_q.delete();
    exp_dup_q.delete();
    exp_q = '{8'd3, 8'd7, 8'd9, 8'd5, 8'd1, 8'd2, 8'd3, 8'd5};
    exp_dup_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  endtask

  // Offers frame (u,d), then drives (nu,nd,hold_valid) on the array inputs
  // while the frame runs; checks stream, stalls, counts and frame timing.
  task automatic run_frame(input logic [N-1:0][W-1:0] u, input logic [N-1:0][W-1:0] d,
                           input logic [N-1:0][W-1:0] nu, input logic [N-1:0][W-1:0] nd,
                           input bit hold_valid, input bit stall,
                           input int exp_u, input int exp_d, input string name);
    int guard;
    int done_at;
    int stalls;
    bit prev_stalled;
    logic [W-1:0] prev_data;
    logic prev_dup;
    logic prev_last;
    logic [W-1:0] e_data;
    logic e_dup;
    out_ready      = 1'b1;
    unique_arr     = u;
    duplicates_arr = d;
    in_valid       = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ready_wait: in_ready=%b expected 1", name, in_ready);
    end
    step();
    in_valid       = hold_valid;
    unique_arr     = nu;
    duplicates_arr = nd;
    tests_run++;
    if (in_ready !== 1'b0 || unique_cnt !== '0 || dup_cnt !== '0) begin
      tests_failed++;
      $display("FAIL %s accept: in_ready=%b ucnt=%0d dcnt=%0d expected 0/0/0",
               name, in_ready, unique_cnt, dup_cnt);
    end
    done_at = -1;
    stalls = 0;
    prev_stalled = 1'b0;
    prev_data = '0;
    prev_dup = 1'b0;
    prev_last = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (cyc > 1) step();
      if (prev_stalled) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_dup !== prev_dup ||
            out_last !== prev_last) begin
          tests_failed++;
          $display("FAIL %s stall_hold: v=%b data=%0h dup=%b last=%b expected 1/%0h/%b/%b",
                   name, out_valid, out_data, out_dup, out_last, prev_data, prev_dup, prev_last);
        end
      end
      if (out_valid !== 1'b1) begin
        tests_run++;
        if (out_data !== '0 || out_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s idle_data: v=%b data=%0h expected 0/0", name, out_valid, out_data);
        end
      end
      if (frame_done === 1'b1) begin
        done_at = cyc;
        break;
      end
      out_ready = stall ? ((cyc % 4 == 1) || (cyc % 4 == 0)) : 1'b1;
      if (out_valid === 1'b1 && out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL %s extra_elem: data=%0h expected none", name, out_data);
        end else begin
          e_data = exp_q.pop_front();
          e_dup  = exp_dup_q.pop_front();
          if (out_data !== e_data || out_dup !== e_dup || out_last !== (exp_q.size() == 0)) begin
            tests_failed++;
            $display("FAIL %s element: data=%0h dup=%b last=%b expected %0h/%b/%b",
                     name, out_data, out_dup, out_last, e_data, e_dup, exp_q.size() == 0);
          end
        end
      end
      prev_stalled = (out_valid === 1'b1) && !out_ready;
      if (prev_stalled) stalls++;
      prev_data = out_data;
      prev_dup  = out_dup;
      prev_last = out_last;
    end
    out_ready = 1'b1;
    tests_run++;
    if (done_at != 2*N + 1 + stalls) begin
      tests_failed++;
      $display("FAIL %s done_time: frame_done at E0+%0d expected E0+%0d", name, done_at, 2*N + 1 + stalls);
    end
    tests_run++;
    if (unique_cnt !== CW'(exp_u) || dup_cnt !== CW'(exp_d) || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s done_counts: ucnt=%0d dcnt=%0d in_ready=%b expected %0d/%0d/0",
               name, unique_cnt, dup_cnt, in_ready, exp_u, exp_d);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s missing: %0d elements not streamed expected 0", name, exp_q.size());
    end
    step();
    tests_run++;
    if (in_ready !== 1'b1 || frame_done !== 1'b0 || unique_cnt !== CW'(exp_u) || dup_cnt !== CW'(exp_d)) begin
      tests_failed++;
      $display("FAIL %s after_done: in_ready=%b done=%b ucnt=%0d dcnt=%0d expected 1/0/%0d/%0d",
               name, in_ready, frame_done, unique_cnt, dup_cnt, exp_u, exp_d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    unique_arr = JUNK;
    duplicates_arr = JUNK;
    repeat (3) step();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_dup !== 1'b0 ||
        out_last !== 1'b0 || frame_done !== 1'b0 || unique_cnt !== '0 || dup_cnt !== '0) begin
      tests_failed++;
      $display("FAIL reset: rdy=%b v=%b data=%0h dup=%b last=%b done=%b ucnt=%0d dcnt=%0d expected 1/0/0/0/0/0/0/0",
               in_ready, out_valid, out_data, out_dup, out_last, frame_done, unique_cnt, dup_cnt);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_mixed();
    load_mixed();
    run_frame(MIX_U, MIX_D, JUNK, JUNK, 1'b0, 1'b0, 6, 2, "mixed");
  endtask

  task automatic test_empty();
    exp_q.delete();
    exp_dup_q.delete();
    run_frame(ZERO, ZERO, JUNK, JUNK, 1'b0, 1'b0, 0, 0, "empty");
  endtask

  task automatic test_backpressure();
    load_mixed();
    run_frame(MIX_U, MIX_D, JUNK, JUNK, 1'b0, 1'b1, 6, 2, "backpressure");
  endtask

  task automatic test_back_to_back();
    load_mixed();
    run_frame(MIX_U, MIX_D, B_U, B_D, 1'b1, 1'b0, 6, 2, "b2b_first");
    exp_q.delete();
    exp_dup_q.delete();
    exp_q = '{8'h11, 8'h22, 8'h33};
    exp_dup_q = '{1'b0, 1'b0, 1'b1};
    run_frame(B_U, B_D, JUNK, JUNK, 1'b0, 1'b0, 2, 1, "b2b_second");
  endtask

  task automatic test_reset_mid();
    int seen;
    int guard;
    out_ready = 1'b1;
    unique_arr = MIX_U;
    duplicates_arr = MIX_D;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    step();
    in_valid = 1'b0;
    seen = 0;
    guard = 0;
    while (guard < 40) begin
      if (out_valid === 1'b1) begin
        if (seen == 2) break;
        seen++;
      end
      step();
      guard++;
    end
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'd9) begin
      tests_failed++;
      $display("FAIL rst_mid third: v=%b data=%0h expected 1/9", out_valid, out_data);
    end
    step();
    rst = 1'b1;
    step();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_dup !== 1'b0 ||
        out_last !== 1'b0 || frame_done !== 1'b0 || unique_cnt !== '0 || dup_cnt !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid outputs: rdy=%b v=%b data=%0h dup=%b last=%b done=%b ucnt=%0d dcnt=%0d expected 1/0/0/0/0/0/0/0",
               in_ready, out_valid, out_data, out_dup, out_last, frame_done, unique_cnt, dup_cnt);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    load_mixed();
    run_frame(MIX_U, MIX_D, JUNK, JUNK, 1'b0, 1'b0, 6, 2, "rst_mid_restart");
  endtask

  task automatic test_dup_only();
    exp_q.delete();
    exp_dup_q.delete();
    exp_q = '{8'd4};
    exp_dup_q = '{1'b1};
    run_frame(ZERO, DO_D, JUNK, JUNK, 1'b0, 1'b0, 0, 1, "dup_only");
  endtask

  initial begin
    test_reset();
    test_mixed();
    test_empty();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_dup_only();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
